// File: rtl/line_bcd_encoder_pkg.sv
// line_bcd_encoder_pkg: shared code constant and FSM state encoding for the select-line encoder.
package robotron_sound_pkg;

    localparam logic [3:0] CODE_NONE = 4'hF;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        PRESENT  = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

endpackage

// File: rtl/line_bcd_encoder_if.sv
// line_bcd_encoder_if: select lines in, BCD digit out over valid/ready.
// multi_err is present only when LINE_BCD_MULTI_ERR_EN is defined.
interface line_bcd_encoder_if;

    logic [9:0] in_n;
    logic [3:0] out_bcd;
    logic       out_valid;
    logic       out_ready;
`ifdef LINE_BCD_MULTI_ERR_EN
    logic       multi_err;

    modport master (input in_n, out_ready, output out_bcd, out_valid, multi_err);
    modport slave  (output in_n, out_ready, input out_bcd, out_valid, multi_err);
`else
    modport master (input in_n, out_ready, output out_bcd, out_valid);
    modport slave  (output in_n, out_ready, input out_bcd, out_valid);
`endif

endinterface

// File: rtl/line_bcd_encoder_sync.sv
// sync_2ff: WIDTH-bit two-flop synchroniser; resets to all ones for idle-high lines.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/line_bcd_encoder.sv
// line_bcd_encoder: debounced priority encoder of ten active-low select lines, one event per press.
// Optional LINE_BCD_MULTI_ERR_EN adds multi_err, flagging more than one line low in the accepted sample.
module line_bcd_encoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input logic                clk,
    input logic                reset,
    line_bcd_encoder_if.master bus
);

    import robotron_sound_pkg::*;

    logic [9:0]       lines;
    logic [3:0]       code;
    logic [3:0]       code_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             stable;
    logic             load;
    logic             xfer;
    logic [3:0]       bcd;
    state_t           state;
    state_t           state_d;

    sync_2ff #(.WIDTH(10)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.in_n),
        .q     (lines)
    );

    always_comb begin
        code = CODE_NONE;
        for (int i = 0; i < 10; i++)
            if (!lines[i]) code = 4'(i);
    end

    // Judging stability on the count the register is about to take saves a cycle of latency.
    assign cnt_d  = (code != code_q) ? '0 :
                    (cnt == CNT_W'(STABLE_CYCLES)) ? cnt : cnt + 1'b1;
    assign stable = (cnt_d == CNT_W'(STABLE_CYCLES));
    assign xfer   = (state == PRESENT) && bus.out_ready;

    always_comb begin
        state_d = state;
        load    = 1'b0;
        case (state)
            ARMED: begin
                load    = stable && (code != CODE_NONE);
                state_d = load ? PRESENT : ARMED;
            end
            PRESENT:  state_d = bus.out_ready ? WAIT_REL : PRESENT;
            WAIT_REL: state_d = (stable && (code == CODE_NONE)) ? ARMED : WAIT_REL;
            default:  state_d = ARMED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ARMED;
            code_q <= CODE_NONE;
            cnt    <= '0;
            bcd    <= CODE_NONE;
        end else begin
            state  <= state_d;
            code_q <= code;
            cnt    <= cnt_d;
            if (load) bcd <= code;
        end
    end

    assign bus.out_bcd   = bcd;
    assign bus.out_valid = (state == PRESENT);

`ifdef LINE_BCD_MULTI_ERR_EN
    logic multi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            multi <= 1'b0;
        else if (load)
            multi <= ($countones(~lines) > 1);
        else if (xfer)
            multi <= 1'b0;
    end

    assign bus.multi_err = multi;
`else
    logic unused_xfer;
    assign unused_xfer = xfer;
`endif

endmodule
